// File: rtl/az_sample_accumulator.sv
// Auto-zero sample accumulator: sums ADC samples over HI then LO windows and publishes sums, counts and saturated HI-LO.
// Result regs load 2 clocks after lo_window is first sampled low; no backpressure, result_valid is a 1-cycle strobe.
module az_sample_accumulator #(
  parameter int DATA_W = 24,
  parameter int ACC_W  = 48,
  parameter int CNT_W  = 24
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     hi_window,
  input  logic                     lo_window,
  input  logic                     adc_valid,
  input  logic signed [DATA_W-1:0] adc_data,
  input  logic                     clear_err,
  output logic signed [ACC_W-1:0]  hi_sum,
  output logic signed [ACC_W-1:0]  lo_sum,
  output logic signed [ACC_W-1:0]  diff,
  output logic [CNT_W-1:0]         hi_count,
  output logic [CNT_W-1:0]         lo_count,
  output logic                     result_valid,
  output logic [7:0]               result_seq,
  output logic                     sat_flag,
  output logic                     protocol_err,
  output logic [2:0]               state_mon
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HI_ACC  = 3'd1,
    WAIT_LO = 3'd2,
    LO_ACC  = 3'd3,
    PUBLISH = 3'd4
  } state_t;

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state;
  logic [ACC_W-1:0] hi_acc;
  logic [ACC_W-1:0] lo_acc;
  logic [CNT_W-1:0] hi_cnt;
  logic [CNT_W-1:0] lo_cnt;
  logic             pair_sat;

  logic [ACC_W-1:0] sample_ext;
  logic [ACC_W-1:0] first_acc;
  logic [CNT_W-1:0] first_cnt;
  logic [ACC_W:0]   hi_wide;
  logic [ACC_W:0]   lo_wide;
  logic [ACC_W:0]   diff_wide;
  logic             hi_ovf;
  logic             lo_ovf;
  logic             diff_ovf;
  logic [ACC_W-1:0] hi_step;
  logic [ACC_W-1:0] lo_step;
  logic [ACC_W-1:0] diff_val;
  logic             hi_cnt_max;
  logic             lo_cnt_max;
  logic             both_windows;

  // One extra guard bit: overflow shows up as the top two bits disagreeing.
  always_comb begin
    sample_ext   = {{(ACC_W-DATA_W){adc_data[DATA_W-1]}}, adc_data};
    first_acc    = adc_valid ? sample_ext : '0;
    first_cnt    = adc_valid ? CNT_ONE : '0;

    hi_wide      = {hi_acc[ACC_W-1], hi_acc} + {sample_ext[ACC_W-1], sample_ext};
    hi_ovf       = hi_wide[ACC_W] ^ hi_wide[ACC_W-1];
    hi_step      = hi_ovf ? (hi_wide[ACC_W] ? ACC_MIN : ACC_MAX) : hi_wide[ACC_W-1:0];

    lo_wide      = {lo_acc[ACC_W-1], lo_acc} + {sample_ext[ACC_W-1], sample_ext};
    lo_ovf       = lo_wide[ACC_W] ^ lo_wide[ACC_W-1];
    lo_step      = lo_ovf ? (lo_wide[ACC_W] ? ACC_MIN : ACC_MAX) : lo_wide[ACC_W-1:0];

    diff_wide    = {hi_acc[ACC_W-1], hi_acc} - {lo_acc[ACC_W-1], lo_acc};
    diff_ovf     = diff_wide[ACC_W] ^ diff_wide[ACC_W-1];
    diff_val     = diff_ovf ? (diff_wide[ACC_W] ? ACC_MIN : ACC_MAX) : diff_wide[ACC_W-1:0];

    hi_cnt_max   = &hi_cnt;
    lo_cnt_max   = &lo_cnt;
    both_windows = hi_window & lo_window;
  end

  assign state_mon = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      hi_acc       <= '0;
      lo_acc       <= '0;
      hi_cnt       <= '0;
      lo_cnt       <= '0;
      pair_sat     <= 1'b0;
      hi_sum       <= '0;
      lo_sum       <= '0;
      diff         <= '0;
      hi_count     <= '0;
      lo_count     <= '0;
      result_valid <= 1'b0;
      result_seq   <= '0;
      sat_flag     <= 1'b0;
      protocol_err <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      if (clear_err) begin
        protocol_err <= 1'b0;
      end

      // A window overlap aborts whatever pair is in flight; the set overrides clear_err.
      if (both_windows) begin
        protocol_err <= 1'b1;
        state        <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (hi_window) begin
              hi_acc   <= first_acc;
              hi_cnt   <= first_cnt;
              pair_sat <= 1'b0;
              state    <= HI_ACC;
            end
          end

          HI_ACC: begin
            if (!hi_window) begin
              state <= WAIT_LO;
            end else if (adc_valid) begin
              hi_acc <= hi_step;
              if (hi_ovf) begin
                pair_sat <= 1'b1;
              end
              if (hi_cnt_max) begin
                pair_sat <= 1'b1;
              end else begin
                hi_cnt <= hi_cnt + CNT_ONE;
              end
            end
          end

          WAIT_LO: begin
            if (lo_window) begin
              lo_acc <= first_acc;
              lo_cnt <= first_cnt;
              state  <= LO_ACC;
            end else if (hi_window) begin
              hi_acc   <= first_acc;
              hi_cnt   <= first_cnt;
              pair_sat <= 1'b0;
              state    <= HI_ACC;
            end
          end

          LO_ACC: begin
            if (!lo_window) begin
              state <= PUBLISH;
            end else if (adc_valid) begin
              lo_acc <= lo_step;
              if (lo_ovf) begin
                pair_sat <= 1'b1;
              end
              if (lo_cnt_max) begin
                pair_sat <= 1'b1;
              end else begin
                lo_cnt <= lo_cnt + CNT_ONE;
              end
            end
          end

          PUBLISH: begin
            hi_sum       <= hi_acc;
            lo_sum       <= lo_acc;
            diff         <= diff_val;
            hi_count     <= hi_cnt;
            lo_count     <= lo_cnt;
            sat_flag     <= pair_sat | diff_ovf;
            result_valid <= 1'b1;
            result_seq   <= result_seq + 8'd1;
            // An immediately following HI window starts here so its first sample is not lost.
            if (hi_window) begin
              hi_acc   <= first_acc;
              hi_cnt   <= first_cnt;
              pair_sat <= 1'b0;
              state    <= HI_ACC;
            end else begin
              state <= IDLE;
            end
          end

          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/az_sample_accumulator.md
Name: az_sample_accumulator

Overview:
- Sits directly downstream of the auto-zero modulator. Consumes its HI-sample and LO-sample window levels, plus the ADC sample stream.
- Accumulates ADC samples separately in each window.
- On completion of each HI-then-LO pair, publishes both sums, both counts and the AZ-corrected difference HI − LO, with a one-cycle valid strobe.

Parameters:
- DATA_W, 24, width of signed ADC sample
- ACC_W, 48, width of signed accumulators and difference
- CNT_W, 24, width of per-window sample counters

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- hi_window  in  1  level; high while modulator is in HI (signal) sample phase
- lo_window  in  1  level; high while modulator is in LO sample phase
- adc_valid  in  1  single-cycle strobe, adc_data valid
- adc_data  in  DATA_W  signed two's-complement ADC sample
- clear_err  in  1  synchronous pulse, clears protocol_err
- hi_sum  out  ACC_W  signed sum of HI-window samples, last completed pair
- lo_sum  out  ACC_W  signed sum of LO-window samples, last completed pair
- diff  out  ACC_W  hi_sum − lo_sum, saturated
- hi_count  out  CNT_W  samples accumulated in HI window
- lo_count  out  CNT_W  samples accumulated in LO window
- result_valid  out  1  one-cycle pulse when outputs update
- result_seq  out  8  increments per published result, wraps 255→0
- sat_flag  out  1  accumulator or diff saturated in the published pair
- protocol_err  out  1  sticky; set when hi_window and lo_window are high in the same cycle
- state_mon  out  3  current state encoding, for monitor pins

Behaviour:
- Reset (reset_n low, async) drives all outputs, accumulators, counters and result_seq to 0, and state to IDLE. Reset mid-pair discards the partial pair; no result is emitted.
- States: IDLE=0, HI_ACC=1, WAIT_LO=2, LO_ACC=3, PUBLISH=4.
- IDLE: hi_window=1 → HI_ACC. The working hi accumulator and hi counter load the current cycle's sample (if adc_valid) or 0.
- HI_ACC: each cycle with adc_valid=1 adds sign-extended adc_data and increments the counter. hi_window=0 → WAIT_LO; a sample arriving in that cycle is ignored.
- WAIT_LO: lo_window=1 → LO_ACC, loading the first sample as in IDLE→HI_ACC. hi_window=1 instead → restart HI_ACC, discarding the working hi values.
- LO_ACC: accumulate as in HI_ACC. lo_window=0 → PUBLISH.
- PUBLISH (one cycle): register hi_sum, lo_sum, counts, diff and sat_flag; result_valid=1; result_seq+1; next state IDLE.
  - If hi_window is already high in this cycle, the next state is HI_ACC with that cycle's sample taken.
- Latency: outputs and result_valid appear 2 clocks after the first cycle lo_window is sampled low.
- Output registers hold their value between pulses.
- Arithmetic:
  - Accumulators saturate at ±(2^(ACC_W−1)−1 / −2^(ACC_W−1)) and never wrap.
  - Counters saturate at all-ones.
  - Any saturation sets the pair's sat flag.
  - diff is computed at full precision and saturated to ACC_W; diff saturation also sets sat_flag.
- Zero-sample windows are legal: sum=0, count=0, result still published.
- Both windows high in the same cycle: protocol_err←1, state→IDLE, partial pair discarded.
- clear_err clears protocol_err. If a new violation coincides with clear_err, the set wins.
- Samples outside any window are ignored.
- lo_window rising while in IDLE (no preceding HI) is ignored until the next hi_window rise.

Test Plan:
- Normal pair: HI window with 4 samples of +1000, then LO window with 4 samples of −200 → hi_sum=4000, lo_sum=−800, diff=4800, counts 4/4, result_valid one pulse, result_seq=1.
- Back-to-back: hi_window rises in the PUBLISH cycle with adc_valid=1 (data=7) → result from first pair published; second pair hi_sum includes 7; no sample is lost.
- Saturation: DATA_W=24, ACC_W=26, HI window with 20 samples of 0x7FFFFF → hi_sum=2^25−1, sat_flag=1. Next clean pair → sat_flag=0.
- Protocol error: assert both windows for 1 cycle mid HI_ACC → protocol_err=1, no result_valid, state_mon=0. clear_err pulse → protocol_err=0.
- Reset mid-LO_ACC: reset_n low for 3 cycles → all outputs 0, no pulse. A subsequent full pair publishes with result_seq=1.
- Zero-sample / orphan: lo_window pulse while in IDLE → ignored. HI window with no adc_valid then LO with 2 samples of 5 → hi_count=0, lo_sum=10, diff=−10.
